// File: rtl/ma_commit_rob.sv
// ma_commit_rob: in-order commit buffer for multiply-add results returned out of order.
// Define MA_COMMIT_BYPASS_EN to add a zero-latency write path for in-order head results.
module ma_commit_rob #(
  parameter int NUM_ENTRY   = 8,
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_ISSUE = 8,
  parameter int WIDTH_DST   = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Alloc,
  input  logic [WIDTH_DST-1:0]       I_Alloc_Dst,
  output logic [WIDTH_ISSUE-1:0]     O_Alloc_No,
  input  logic                       I_Valid,
  input  logic [WIDTH_ISSUE-1:0]     I_Issue_No,
  input  logic [WIDTH_DATA-1:0]      I_Data,
  output logic                       O_We,
  output logic [WIDTH_DST-1:0]       O_WAddr,
  output logic [WIDTH_DATA-1:0]      O_WData,
  input  logic                       I_Grant,
  output logic                       O_Stall,
  output logic                       O_Empty,
  output logic [$clog2(NUM_ENTRY):0] O_Num,
  output logic                       O_Err
);
  localparam int IDX_W = $clog2(NUM_ENTRY);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state_reg;
  logic [WIDTH_ISSUE-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0]       num_reg, num_next;
  logic                   stall_reg, err_reg, we_reg;
  logic [WIDTH_DST-1:0]   waddr_reg;
  logic [WIDTH_DATA-1:0]  wdata_reg;
  logic [NUM_ENTRY-1:0]   done_reg;
  logic [WIDTH_DST-1:0]   dst_mem  [NUM_ENTRY];
  logic [WIDTH_DATA-1:0]  data_mem [NUM_ENTRY];

  logic [IDX_W-1:0]       head_idx, tail_idx, res_idx;
  logic [WIDTH_ISSUE-1:0] res_off;
  logic                   in_window, alloc_ok, res_ok, bypass_hit, commit_ok, res_write;

  assign head_idx  = head_reg[IDX_W-1:0];
  assign tail_idx  = tail_reg[IDX_W-1:0];
  assign res_idx   = I_Issue_No[IDX_W-1:0];
  // Modular distance from head keeps the window check correct across counter wrap.
  assign res_off   = I_Issue_No - head_reg;
  assign in_window = {1'b0, res_off} < (WIDTH_ISSUE+1)'(num_reg);
  assign alloc_ok  = I_Alloc && !stall_reg;
  assign res_ok    = I_Valid && in_window && !done_reg[res_idx];

`ifdef MA_COMMIT_BYPASS_EN
  assign bypass_hit = (state_reg == IDLE) && res_ok && (I_Issue_No == head_reg);
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_ok = ((state_reg == HOLD) || bypass_hit) && I_Grant;
  // A bypassed result that is granted immediately never lands in the slot.
  assign res_write = res_ok && !(bypass_hit && I_Grant);

  always_comb begin
    num_next = num_reg;
    if (alloc_ok && !commit_ok)
      num_next = num_reg + CNT_W'(1);
    else if (!alloc_ok && commit_ok)
      num_next = num_reg - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      num_reg   <= '0;
      stall_reg <= 1'b0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      done_reg  <= '0;
    end else begin
      if (alloc_ok) begin
        done_reg[tail_idx] <= 1'b0;
        tail_reg           <= tail_reg + 1'b1;
      end
      if (res_write)
        done_reg[res_idx] <= 1'b1;
      if (commit_ok) begin
        done_reg[head_idx] <= 1'b0;
        head_reg           <= head_reg + 1'b1;
      end
      num_reg   <= num_next;
      stall_reg <= (num_next == CNT_W'(NUM_ENTRY));
      err_reg   <= I_Valid && !res_ok;

      case (state_reg)
        IDLE: begin
          if (bypass_hit && !I_Grant) begin
            state_reg <= HOLD;
            we_reg    <= 1'b1;
            waddr_reg <= dst_mem[head_idx];
            wdata_reg <= I_Data;
          end else if (done_reg[head_idx] && (num_reg != '0)) begin
            state_reg <= HOLD;
            we_reg    <= 1'b1;
            waddr_reg <= dst_mem[head_idx];
            wdata_reg <= data_mem[head_idx];
          end
        end
        HOLD: begin
          if (I_Grant) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_ok)
      dst_mem[tail_idx] <= I_Alloc_Dst;
    if (res_write)
      data_mem[res_idx] <= I_Data;
  end

  assign O_Alloc_No = tail_reg;
  assign O_We       = we_reg || bypass_hit;
  assign O_WAddr    = bypass_hit ? dst_mem[head_idx] : waddr_reg;
  assign O_WData    = bypass_hit ? I_Data : wdata_reg;
  assign O_Stall    = stall_reg;
  assign O_Empty    = (num_reg == '0);
  assign O_Num      = num_reg;
  assign O_Err      = err_reg;

endmodule

// File: tb/tb_ma_commit_rob.sv
// Directed testbench for ma_commit_rob: ordering, full/stall, hold, error pulses, wrap, reset.
`timescale 1ns/1ps
module tb_ma_commit_rob;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        I_Alloc = 1'b0;
  logic [5:0]  I_Alloc_Dst = '0;
  logic [7:0]  O_Alloc_No;
  logic        I_Valid = 1'b0;
  logic [7:0]  I_Issue_No = '0;
  logic [31:0] I_Data = '0;
  logic        O_We;
  logic [5:0]  O_WAddr;
  logic [31:0] O_WData;
  logic        I_Grant = 1'b0;
  logic        O_Stall, O_Empty, O_Err;
  logic [3:0]  O_Num;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0]  wr_addr [16];
  logic [31:0] wr_data [16];

  always #5 clock = ~clock;

  ma_commit_rob #(.NUM_ENTRY(8), .WIDTH_DATA(32), .WIDTH_ISSUE(8), .WIDTH_DST(6)) dut (
    .clock(clock), .reset(reset),
    .I_Alloc(I_Alloc), .I_Alloc_Dst(I_Alloc_Dst), .O_Alloc_No(O_Alloc_No),
    .I_Valid(I_Valid), .I_Issue_No(I_Issue_No), .I_Data(I_Data),
    .O_We(O_We), .O_WAddr(O_WAddr), .O_WData(O_WData), .I_Grant(I_Grant),
    .O_Stall(O_Stall), .O_Empty(O_Empty), .O_Num(O_Num), .O_Err(O_Err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic alloc(input logic [5:0] dst);
    I_Alloc = 1'b1; I_Alloc_Dst = dst;
    tick();
    I_Alloc = 1'b0;
  endtask

  task automatic result(input logic [7:0] no, input logic [31:0] data);
    I_Valid = 1'b1; I_Issue_No = no; I_Data = data;
    tick();
    I_Valid = 1'b0;
  endtask

  // Grants continuously and records each write seen; bounded so it always returns.
  task automatic collect(input int n, output int got);
    got = 0;
    I_Grant = 1'b1;
    for (int c = 0; c < 16 * n + 16 && got < n; c++) begin
      if (O_We) begin
        wr_addr[got] = O_WAddr; wr_data[got] = O_WData;
        $display("[TB] commit addr=%0d data=%0h", O_WAddr, O_WData);
        got++;
      end
      tick();
    end
    I_Grant = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_tests++; if (O_We !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %0b expected 0", O_We); end
    n_tests++; if (O_WAddr !== 6'd0)  begin n_fail++; $display("FAIL reset_waddr: got %0h expected 0", O_WAddr); end
    n_tests++; if (O_WData !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", O_WData); end
    n_tests++; if (O_Stall !== 1'b0)  begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", O_Stall); end
    n_tests++; if (O_Empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", O_Empty); end
    n_tests++; if (O_Num !== 4'd0)    begin n_fail++; $display("FAIL reset_num: got %0d expected 0", O_Num); end
    n_tests++; if (O_Err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %0b expected 0", O_Err); end
    n_tests++; if (O_Alloc_No !== 8'd0) begin n_fail++; $display("FAIL reset_alloc_no: got %0d expected 0", O_Alloc_No); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_out_of_order();
    int got;
    logic [5:0]  exp_a [3] = '{6'd5, 6'd6, 6'd7};
    logic [31:0] exp_d [3] = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (O_Alloc_No !== 8'(i)) begin n_fail++; $display("FAIL ooo_alloc_no: got %0d expected %0d", O_Alloc_No, i); end
      alloc(6'(5 + i));
    end
    n_tests++; if (O_Num !== 4'd3) begin n_fail++; $display("FAIL ooo_num: got %0d expected 3", O_Num); end
    result(8'd2, 32'hC);
    result(8'd0, 32'hA);
    result(8'd1, 32'hB);
    collect(3, got);
    n_tests++; if (got !== 3) begin n_fail++; $display("FAIL ooo_count: got %0d expected 3", got); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL ooo_write%0d: got (%0d,%0h) expected (%0d,%0h)", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
      end
    end
    n_tests++; if (O_Empty !== 1'b1) begin n_fail++; $display("FAIL ooo_empty: got %0b expected 1", O_Empty); end
  endtask

  // head=tail=3 on entry; issues 3..10 get dst 10..17.
  task automatic test_full();
    int got;
    for (int i = 0; i < 8; i++) alloc(6'(10 + i));
    n_tests++; if (O_Num !== 4'd8)   begin n_fail++; $display("FAIL full_num: got %0d expected 8", O_Num); end
    n_tests++; if (O_Stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %0b expected 1", O_Stall); end
    alloc(6'd63);
    n_tests++; if (O_Alloc_No !== 8'd11) begin n_fail++; $display("FAIL full_tail_held: got %0d expected 11", O_Alloc_No); end
    n_tests++; if (O_Num !== 4'd8)   begin n_fail++; $display("FAIL full_num_held: got %0d expected 8", O_Num); end
    I_Grant = 1'b1;
    result(8'd3, 32'h33);
    n_tests++; if (O_We !== 1'b0) begin n_fail++; $display("FAIL full_we_early: got %0b expected 0", O_We); end
    tick();
    n_tests++;
    if (O_We !== 1'b1 || O_WAddr !== 6'd10 || O_WData !== 32'h33) begin
      n_fail++; $display("FAIL full_write: got we=%0b (%0d,%0h) expected we=1 (10,33)", O_We, O_WAddr, O_WData);
    end
    tick();
    I_Grant = 1'b0;
    n_tests++; if (O_Stall !== 1'b0) begin n_fail++; $display("FAIL full_unstall: got %0b expected 0", O_Stall); end
    n_tests++; if (O_Num !== 4'd7)   begin n_fail++; $display("FAIL full_num_after: got %0d expected 7", O_Num); end
    for (int i = 1; i < 8; i++) result(8'(3 + i), 32'(32'h40 + i));
    collect(7, got);
    n_tests++; if (got !== 7) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 7", got); end
    n_tests++;
    if (wr_addr[0] !== 6'd11 || wr_data[6] !== 32'h47 || wr_addr[6] !== 6'd17) begin
      n_fail++; $display("FAIL full_drain: got first addr %0d last (%0d,%0h) expected 11 (17,47)", wr_addr[0], wr_addr[6], wr_data[6]);
    end
    n_tests++; if (O_Empty !== 1'b1) begin n_fail++; $display("FAIL full_empty: got %0b expected 1", O_Empty); end
  endtask

  // head=tail=11 on entry.
  task automatic test_hold();
    int got;
    alloc(6'h2A);
    alloc(6'h2B);
    result(8'd11, 32'h12345678);
    tick();
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (O_We !== 1'b1 || O_WAddr !== 6'h2A || O_WData !== 32'h12345678) begin
        n_fail++; $display("FAIL hold_stable%0d: got we=%0b (%0h,%0h) expected we=1 (2a,12345678)", c, O_We, O_WAddr, O_WData);
      end
      if (c < 3) tick();
    end
    I_Grant = 1'b1;
    tick();
    I_Grant = 1'b0;
    n_tests++; if (O_We !== 1'b0) begin n_fail++; $display("FAIL hold_we_drop: got %0b expected 0", O_We); end
    n_tests++; if (O_Num !== 4'd1) begin n_fail++; $display("FAIL hold_num: got %0d expected 1", O_Num); end
    result(8'd12, 32'h55);
    collect(1, got);
    n_tests++;
    if (got !== 1 || wr_addr[0] !== 6'h2B || wr_data[0] !== 32'h55) begin
      n_fail++; $display("FAIL hold_second: got %0d writes (%0h,%0h) expected 1 (2b,55)", got, wr_addr[0], wr_data[0]);
    end
  endtask

  // head=tail=13 on entry; issues 13,14,15 in flight.
  task automatic test_err();
    int got;
    alloc(6'h11); alloc(6'h12); alloc(6'h13);
    result(8'd18, 32'hBAD);
    n_tests++; if (O_Err !== 1'b1) begin n_fail++; $display("FAIL err_window: got %0b expected 1", O_Err); end
    tick();
    n_tests++; if (O_Err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %0b expected 0", O_Err); end
    result(8'd14, 32'hB1);
    n_tests++; if (O_Err !== 1'b0) begin n_fail++; $display("FAIL err_good: got %0b expected 0", O_Err); end
    result(8'd14, 32'hDEAD);
    n_tests++; if (O_Err !== 1'b1) begin n_fail++; $display("FAIL err_dup: got %0b expected 1", O_Err); end
    result(8'd13, 32'hA1);
    result(8'd15, 32'hC1);
    collect(3, got);
    n_tests++;
    if (got !== 3 || wr_addr[1] !== 6'h12 || wr_data[0] !== 32'hA1 || wr_data[1] !== 32'hB1 || wr_data[2] !== 32'hC1) begin
      n_fail++; $display("FAIL err_data: got %0d writes data %0h %0h %0h addr1 %0h expected 3 a1 b1 c1 12",
                         got, wr_data[0], wr_data[1], wr_data[2], wr_addr[1]);
    end
  endtask

  // head=tail=16 on entry; 300 single-instruction round trips cross 255->0.
  task automatic test_wrap();
    logic [7:0] no;
    bit seen;
    for (int i = 0; i < 300; i++) begin
      no = 8'((16 + i) % 256);
      n_tests++; if (O_Alloc_No !== no) begin n_fail++; $display("FAIL wrap_alloc_no%0d: got %0d expected %0d", i, O_Alloc_No, no); end
      alloc(6'(i % 64));
      result(no, 32'(i * 3 + 1));
      I_Grant = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        if (O_We) seen = 1'b1; else tick();
      end
      n_tests++;
      if (!seen || O_WAddr !== 6'(i % 64) || O_WData !== 32'(i * 3 + 1) || O_Err !== 1'b0) begin
        n_fail++; $display("FAIL wrap_write%0d: got we=%0b (%0d,%0h) err=%0b expected we=1 (%0d,%0h) err=0",
                           i, O_We, O_WAddr, O_WData, O_Err, i % 64, i * 3 + 1);
      end else begin
        $display("[TB] wrap issue=%0d addr=%0d data=%0h", no, O_WAddr, O_WData);
      end
      tick();
      I_Grant = 1'b0;
    end
    n_tests++; if (O_Alloc_No !== 8'd60) begin n_fail++; $display("FAIL wrap_tail: got %0d expected 60", O_Alloc_No); end
    n_tests++; if (O_Empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %0b expected 1", O_Empty); end
  endtask

  task automatic test_reset_mid();
    alloc(6'd9);
    result(8'd60, 32'h99);
    tick();
    n_tests++; if (O_We !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %0b expected 1", O_We); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (O_We !== 1'b0) begin n_fail++; $display("FAIL rst_async_we: got %0b expected 0", O_We); end
    tick();
    reset = 1'b1;
    tick();
    n_tests++; if (O_Empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %0b expected 1", O_Empty); end
    n_tests++; if (O_Alloc_No !== 8'd0) begin n_fail++; $display("FAIL rst_alloc_no: got %0d expected 0", O_Alloc_No); end
    n_tests++; if (O_We !== 1'b0) begin n_fail++; $display("FAIL rst_we_after: got %0b expected 0", O_We); end
  endtask

  initial begin
    test_reset();
    test_out_of_order();
    test_full();
    test_hold();
    test_err();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
